// File: rtl/itlb_ptw.sv
// itlb_ptw: fully-associative instruction TLB backed by an Sv32 two-level
// hardware page-table walker. Hits and bare-mode translations respond in the
// same cycle. A miss starts a walk, and the walk result is then returned
// through the normal hit path (or through the fault register) one cycle later.
module itlb_ptw #(
    parameter int TLB_ENTRIES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mmu_vaddr_i,
    input  logic        mmu_req_valid_i,
    output logic [31:0] mmu_paddr_o,
    output logic        mmu_resp_valid_o,
    output logic        mmu_page_fault_o,
    input  logic        mmu_enable_i,
    input  logic [21:0] mmu_satp_ppn_i,
    input  logic [8:0]  mmu_satp_asid_i,
    input  logic        mmu_priv_u_i,
    input  logic        mmu_flush_i,
    output logic        mmu_mem_req_o,
    output logic [31:0] mmu_mem_addr_o,
    input  logic [31:0] mmu_mem_rdata_i,
    input  logic        mmu_mem_rvalid_i
);

    localparam int IDX_W = $clog2(TLB_ENTRIES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_L1_REQ = 2'd1;
    localparam logic [1:0] S_L0_REQ = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]  state;
    logic [19:0] walk_vpn;
    logic [8:0]  walk_asid;
    logic        walk_priv_u;
    logic        abort;

    // Result of the walk, held for the DONE cycle.
    logic        leaf_fault;
    logic        leaf_super;
    logic        leaf_g;
    logic [19:0] leaf_ppn;

    logic [IDX_W-1:0]     rr_ptr;
    logic [TLB_ENTRIES-1:0] tlb_valid;
    logic [TLB_ENTRIES-1:0] tlb_g;
    logic [TLB_ENTRIES-1:0] tlb_super;
    logic [19:0] tlb_vpn  [TLB_ENTRIES];
    logic [8:0]  tlb_asid [TLB_ENTRIES];
    logic [19:0] tlb_ppn  [TLB_ENTRIES];

    logic        fault_valid;
    logic [19:0] fault_vpn;
    logic [8:0]  fault_asid;

    logic        tlb_hit;
    logic [31:0] hit_paddr;
    logic        fault_hit;

    // PTE field decode of the word being returned by memory.
    logic        pte_v, pte_r, pte_w, pte_x, pte_u, pte_g, pte_a;
    logic [19:0] pte_ppn;
    logic        pte_invalid, pte_leaf, leaf_bad, l1_fault, l0_fault;
    logic        start_walk, fill, record_fault;
    logic        unused_bits;

    assign pte_v   = mmu_mem_rdata_i[0];
    assign pte_r   = mmu_mem_rdata_i[1];
    assign pte_w   = mmu_mem_rdata_i[2];
    assign pte_x   = mmu_mem_rdata_i[3];
    assign pte_u   = mmu_mem_rdata_i[4];
    assign pte_g   = mmu_mem_rdata_i[5];
    assign pte_a   = mmu_mem_rdata_i[6];
    assign pte_ppn = mmu_mem_rdata_i[29:10];

    // Physical addresses are truncated to 32 bits, so the top PPN bits, the
    // dirty bit and the top satp PPN bits never influence anything.
    assign unused_bits = ^{mmu_mem_rdata_i[31:30], mmu_mem_rdata_i[7], mmu_satp_ppn_i[21:20]};

    assign pte_invalid = !pte_v || (!pte_r && pte_w);
    assign pte_leaf    = pte_r || pte_x;
    assign leaf_bad    = !pte_x || !pte_a || (pte_u != walk_priv_u);
    assign l1_fault    = pte_invalid || leaf_bad || (mmu_mem_rdata_i[19:10] != 10'd0);
    assign l0_fault    = pte_invalid || !pte_leaf || leaf_bad;

    // Associative lookup of the current fetch address against all entries.
    always_comb begin
        tlb_hit   = 1'b0;
        hit_paddr = 32'd0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            if (tlb_valid[i] && (tlb_g[i] || tlb_asid[i] == mmu_satp_asid_i) &&
                tlb_vpn[i][19:10] == mmu_vaddr_i[31:22] &&
                (tlb_super[i] || tlb_vpn[i][9:0] == mmu_vaddr_i[21:12])) begin
                tlb_hit   = 1'b1;
                hit_paddr = {tlb_ppn[i][19:10],
                             tlb_super[i] ? mmu_vaddr_i[21:12] : tlb_ppn[i][9:0],
                             mmu_vaddr_i[11:0]};
            end
        end
    end

    assign fault_hit = fault_valid && fault_vpn == mmu_vaddr_i[31:12] &&
                       fault_asid == mmu_satp_asid_i;

    assign mmu_resp_valid_o = mmu_req_valid_i && (!mmu_enable_i || tlb_hit || fault_hit);
    assign mmu_page_fault_o = mmu_resp_valid_o && fault_hit && mmu_enable_i;
    assign mmu_paddr_o      = mmu_enable_i ? hit_paddr : mmu_vaddr_i;

    assign start_walk   = (state == S_IDLE) && mmu_req_valid_i && mmu_enable_i &&
                          !tlb_hit && !fault_hit && !mmu_flush_i;
    assign fill         = (state == S_DONE) && !leaf_fault && !abort && !mmu_flush_i;
    assign record_fault = (state == S_DONE) &&  leaf_fault && !abort && !mmu_flush_i;

    // Walk sequencer: holds the PTE read until rvalid, decodes each level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            mmu_mem_req_o  <= 1'b0;
            mmu_mem_addr_o <= 32'd0;
            walk_vpn       <= 20'd0;
            walk_asid      <= 9'd0;
            walk_priv_u    <= 1'b0;
            abort          <= 1'b0;
            leaf_fault     <= 1'b0;
            leaf_super     <= 1'b0;
            leaf_g         <= 1'b0;
            leaf_ppn       <= 20'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_walk) begin
                        state          <= S_L1_REQ;
                        mmu_mem_req_o  <= 1'b1;
                        mmu_mem_addr_o <= {mmu_satp_ppn_i[19:0], mmu_vaddr_i[31:22], 2'b00};
                        walk_vpn       <= mmu_vaddr_i[31:12];
                        walk_asid      <= mmu_satp_asid_i;
                        walk_priv_u    <= mmu_priv_u_i;
                        abort          <= 1'b0;
                    end
                end
                S_L1_REQ, S_L0_REQ: begin
                    if (mmu_flush_i) begin
                        abort <= 1'b1;
                    end
                    if (mmu_mem_rvalid_i) begin
                        if (abort || mmu_flush_i) begin
                            state         <= S_IDLE;
                            mmu_mem_req_o <= 1'b0;
                            abort         <= 1'b0;
                        end else if (state == S_L1_REQ && !pte_invalid && !pte_leaf) begin
                            state          <= S_L0_REQ;
                            mmu_mem_addr_o <= {pte_ppn, walk_vpn[9:0], 2'b00};
                        end else begin
                            state         <= S_DONE;
                            mmu_mem_req_o <= 1'b0;
                            leaf_fault    <= (state == S_L1_REQ) ? l1_fault : l0_fault;
                            leaf_super    <= (state == S_L1_REQ);
                            leaf_g        <= pte_g;
                            leaf_ppn      <= pte_ppn;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    abort <= 1'b0;
                end
            endcase
        end
    end

    // TLB entries, round-robin replacement pointer and the fault register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            tlb_valid   <= '0;
            tlb_g       <= '0;
            tlb_super   <= '0;
            fault_valid <= 1'b0;
            fault_vpn   <= 20'd0;
            fault_asid  <= 9'd0;
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                tlb_vpn[i]  <= 20'd0;
                tlb_asid[i] <= 9'd0;
                tlb_ppn[i]  <= 20'd0;
            end
        end else if (mmu_flush_i) begin
            tlb_valid   <= '0;
            fault_valid <= 1'b0;
        end else begin
            if (fill) begin
                tlb_valid[rr_ptr] <= 1'b1;
                tlb_g[rr_ptr]     <= leaf_g;
                tlb_super[rr_ptr] <= leaf_super;
                tlb_vpn[rr_ptr]   <= walk_vpn;
                tlb_asid[rr_ptr]  <= walk_asid;
                tlb_ppn[rr_ptr]   <= leaf_ppn;
                rr_ptr            <= rr_ptr + IDX_W'(1);
            end
            if (record_fault) begin
                fault_valid <= 1'b1;
                fault_vpn   <= walk_vpn;
                fault_asid  <= walk_asid;
            end else if (start_walk) begin
                fault_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_itlb_ptw.sv
// tb_itlb_ptw: directed vectors for itlb_ptw with a small page-table memory
// model that answers PTE reads after a programmable number of cycles.
module tb_itlb_ptw;

    localparam int N_ENTRIES = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] mmu_vaddr_i;
    logic        mmu_req_valid_i;
    logic [31:0] mmu_paddr_o;
    logic        mmu_resp_valid_o;
    logic        mmu_page_fault_o;
    logic        mmu_enable_i;
    logic [21:0] mmu_satp_ppn_i;
    logic [8:0]  mmu_satp_asid_i;
    logic        mmu_priv_u_i;
    logic        mmu_flush_i;
    logic        mmu_mem_req_o;
    logic [31:0] mmu_mem_addr_o;
    logic [31:0] mmu_mem_rdata_i;
    logic        mmu_mem_rvalid_i;

    int checks = 0;
    int errors = 0;
    int mem_delay = 0;
    int wait_cnt = 0;
    logic [31:0] addr_log [$];
    logic [31:0] mem_a [$];
    logic [31:0] mem_d [$];

    typedef struct {
        logic        do_flush;
        logic        enable;
        logic        priv_u;
        logic [8:0]  asid;
        logic [31:0] vaddr;
        logic [31:0] exp_paddr;
        logic        exp_fault;
        int          exp_reads;
        logic [31:0] exp_addr0;
        logic [31:0] exp_addr1;
    } vec_t;

    vec_t vecs [16];

    itlb_ptw #(.TLB_ENTRIES(N_ENTRIES)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mmu_vaddr_i      (mmu_vaddr_i),
        .mmu_req_valid_i  (mmu_req_valid_i),
        .mmu_paddr_o      (mmu_paddr_o),
        .mmu_resp_valid_o (mmu_resp_valid_o),
        .mmu_page_fault_o (mmu_page_fault_o),
        .mmu_enable_i     (mmu_enable_i),
        .mmu_satp_ppn_i   (mmu_satp_ppn_i),
        .mmu_satp_asid_i  (mmu_satp_asid_i),
        .mmu_priv_u_i     (mmu_priv_u_i),
        .mmu_flush_i      (mmu_flush_i),
        .mmu_mem_req_o    (mmu_mem_req_o),
        .mmu_mem_addr_o   (mmu_mem_addr_o),
        .mmu_mem_rdata_i  (mmu_mem_rdata_i),
        .mmu_mem_rvalid_i (mmu_mem_rvalid_i)
    );

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        logic [31:0] d;
        d = 32'd0;
        for (int i = 0; i < mem_a.size(); i++) begin
            if (mem_a[i] == a) d = mem_d[i];
        end
        return d;
    endfunction

    task automatic set_mem(input logic [31:0] a, input logic [31:0] d);
        mem_a.push_back(a);
        mem_d.push_back(d);
    endtask

    function automatic vec_t mk(input logic f, input logic en, input logic pu, input logic [8:0] asid,
                                input logic [31:0] va, input logic [31:0] pa, input logic flt,
                                input int reads, input logic [31:0] a0, input logic [31:0] a1);
        vec_t v;
        v.do_flush = f;   v.enable = en;     v.priv_u = pu;      v.asid = asid;
        v.vaddr = va;     v.exp_paddr = pa;  v.exp_fault = flt;  v.exp_reads = reads;
        v.exp_addr0 = a0; v.exp_addr1 = a1;
        return v;
    endfunction

    // Page-table memory: answers a held request mem_delay cycles after it appears.
    always @(negedge clk) begin
        if (mmu_mem_rvalid_i) begin
            mmu_mem_rvalid_i = 1'b0;
            wait_cnt = 0;
        end
        if (rst_n && mmu_mem_req_o) begin
            if (wait_cnt >= mem_delay) begin
                mmu_mem_rvalid_i = 1'b1;
                mmu_mem_rdata_i  = mem_read(mmu_mem_addr_o);
                addr_log.push_back(mmu_mem_addr_o);
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One translation: optional flush cycle, hold the request until a response.
    task automatic applyStimulus(input vec_t v, input string tag);
        int lat;
        int start;
        int reads;
        int exp_lat;
        logic timed_out;
        if (v.do_flush) begin
            mmu_flush_i = 1'b1;
            @(negedge clk);
            mmu_flush_i = 1'b0;
        end
        mmu_enable_i    = v.enable;
        mmu_priv_u_i    = v.priv_u;
        mmu_satp_asid_i = v.asid;
        mmu_vaddr_i     = v.vaddr;
        mmu_req_valid_i = 1'b1;
        start = addr_log.size();
        lat = 0;
        timed_out = 1'b0;
        #1;
        while (!mmu_resp_valid_o && !timed_out) begin
            @(negedge clk);
            #1;
            lat++;
            if (lat > 60) timed_out = 1'b1;
        end
        reads = addr_log.size() - start;
        exp_lat = (v.exp_reads == 0) ? 0 : v.exp_reads * (mem_delay + 1) + 2;
        checkOutput($sformatf("%s timeout", tag), 32'(timed_out), 32'd0);
        checkOutput($sformatf("%s fault", tag), 32'(mmu_page_fault_o), 32'(v.exp_fault));
        if (!v.exp_fault) checkOutput($sformatf("%s paddr", tag), mmu_paddr_o, v.exp_paddr);
        checkOutput($sformatf("%s pte reads", tag), 32'(reads), 32'(v.exp_reads));
        checkOutput($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
        if (reads >= 1 && v.exp_reads >= 1)
            checkOutput($sformatf("%s l1 addr", tag), addr_log[start], v.exp_addr0);
        if (reads >= 2 && v.exp_reads >= 2)
            checkOutput($sformatf("%s l0 addr", tag), addr_log[start+1], v.exp_addr1);
        mmu_req_valid_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        clk = 1'b0;
        rst_n = 1'b0;
        mmu_vaddr_i = 32'h3000_1234;
        mmu_req_valid_i = 1'b1;
        mmu_enable_i = 1'b0;
        mmu_satp_ppn_i = 22'h080000;
        mmu_satp_asid_i = 9'd0;
        mmu_priv_u_i = 1'b0;
        mmu_flush_i = 1'b0;
        mmu_mem_rdata_i = 32'd0;
        mmu_mem_rvalid_i = 1'b0;

        set_mem(32'h8000_0400, 32'h2000_0401);
        set_mem(32'h8000_0408, 32'h2010_044B);
        set_mem(32'h8000_040C, 32'h0000_0005);
        set_mem(32'h8000_0410, 32'h2000_0801);
        set_mem(32'h8000_2000, 32'h2000_0801);
        set_mem(32'h8000_1004, 32'h2004_8C4B);
        set_mem(32'h8000_1008, 32'h2004_8C43);
        set_mem(32'h8000_100C, 32'h2004_8C5B);
        set_mem(32'h8000_1010, 32'h2004_8C47);
        for (int k = 0; k < 5; k++)
            set_mem(32'h8000_1018 + 32'(4 * k), 32'h2008_004B + 32'(k << 10));

        //            flush en pu asid vaddr          paddr          flt rd  l1 addr        l0 addr
        vecs[0]  = mk(0, 0, 0, 9'd0, 32'h3000_1234, 32'h3000_1234, 0, 0, 32'h0,         32'h0);
        vecs[1]  = mk(0, 1, 0, 9'd0, 32'h4000_1004, 32'h8012_3004, 0, 2, 32'h8000_0400, 32'h8000_1004);
        vecs[2]  = mk(0, 1, 0, 9'd0, 32'h4000_1FFC, 32'h8012_3FFC, 0, 0, 32'h0,         32'h0);
        vecs[3]  = mk(0, 1, 0, 9'd5, 32'h4000_1008, 32'h8012_3008, 0, 2, 32'h8000_0400, 32'h8000_1004);
        vecs[4]  = mk(0, 1, 0, 9'd0, 32'h4000_2000, 32'h0,         1, 2, 32'h8000_0400, 32'h8000_1008);
        vecs[5]  = mk(0, 1, 0, 9'd0, 32'h4000_2ABC, 32'h0,         1, 0, 32'h0,         32'h0);
        vecs[6]  = mk(0, 1, 0, 9'd0, 32'h4000_3010, 32'h0,         1, 2, 32'h8000_0400, 32'h8000_100C);
        vecs[7]  = mk(1, 1, 1, 9'd0, 32'h4000_3010, 32'h8012_3010, 0, 2, 32'h8000_0400, 32'h8000_100C);
        vecs[8]  = mk(0, 1, 0, 9'd0, 32'h4000_4000, 32'h0,         1, 2, 32'h8000_0400, 32'h8000_1010);
        vecs[9]  = mk(0, 1, 0, 9'd0, 32'h4000_5000, 32'h0,         1, 2, 32'h8000_0400, 32'h8000_1014);
        vecs[10] = mk(0, 1, 0, 9'd0, 32'h4080_0000, 32'h0,         1, 1, 32'h8000_0408, 32'h0);
        vecs[11] = mk(0, 1, 0, 9'd0, 32'h40C0_0000, 32'h0,         1, 1, 32'h8000_040C, 32'h0);
        vecs[12] = mk(0, 1, 0, 9'd0, 32'h4100_0000, 32'h0,         1, 2, 32'h8000_0410, 32'h8000_2000);
        vecs[13] = mk(0, 1, 1, 9'd0, 32'h4000_3FFF, 32'h8012_3FFF, 0, 0, 32'h0,         32'h0);
        vecs[14] = mk(0, 0, 0, 9'd0, 32'h4000_2000, 32'h4000_2000, 0, 0, 32'h0,         32'h0);
        vecs[15] = mk(1, 1, 0, 9'd0, 32'h4000_2000, 32'h0,         1, 2, 32'h8000_0400, 32'h8000_1008);

        // Reset state, with bare-mode passthrough live while reset is held.
        #1;
        checkOutput("reset mem_req", 32'(mmu_mem_req_o), 32'd0);
        checkOutput("reset mem_addr", mmu_mem_addr_o, 32'd0);
        checkOutput("reset bare resp_valid", 32'(mmu_resp_valid_o), 32'd1);
        checkOutput("reset bare paddr", mmu_paddr_o, 32'h3000_1234);
        checkOutput("reset bare fault", 32'(mmu_page_fault_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mmu_req_valid_i = 1'b0;
        @(negedge clk);

        // Reset arriving in the middle of a walk drops it.
        mem_delay = 3;
        mmu_enable_i = 1'b1;
        mmu_vaddr_i = 32'h4000_1004;
        mmu_req_valid_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("midwalk mem_req", 32'(mmu_mem_req_o), 32'd1);
        checkOutput("midwalk l1 addr", mmu_mem_addr_o, 32'h8000_0400);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset mem_req", 32'(mmu_mem_req_o), 32'd0);
        mmu_req_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_delay = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("idle after reset %0d", k), 32'(mmu_mem_req_o), 32'd0);
        end
        @(negedge clk);

        for (int i = 0; i < 16; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Superpage leaf at level 1, then a second page inside it hits.
        mem_d[0] = 32'h2010_004B;
        applyStimulus(mk(1, 1, 0, 9'd0, 32'h4000_1004, 32'h8040_1004, 0, 1, 32'h8000_0400, 32'h0), "super miss");
        applyStimulus(mk(0, 1, 0, 9'd0, 32'h4000_3008, 32'h8040_3008, 0, 0, 32'h0, 32'h0), "super hit");
        mem_d[0] = 32'h2000_0401;

        // Fill one more page than the TLB holds: the oldest one is replaced.
        for (int k = 0; k < N_ENTRIES + 1; k++)
            applyStimulus(mk(k == 0, 1, 0, 9'd0, 32'h4000_6000 + 32'(k << 12), 32'h8020_0000 + 32'(k << 12),
                             0, 2, 32'h8000_0400, 32'h8000_1018 + 32'(4 * k)), $sformatf("evict fill%0d", k));
        for (int k = 1; k < N_ENTRIES + 1; k++)
            applyStimulus(mk(0, 1, 0, 9'd0, 32'h4000_6000 + 32'(k << 12), 32'h8020_0000 + 32'(k << 12),
                             0, 0, 32'h0, 32'h0), $sformatf("evict hit%0d", k));
        applyStimulus(mk(0, 1, 0, 9'd0, 32'h4000_6000, 32'h8020_0000, 0, 2, 32'h8000_0400, 32'h8000_1018),
                      "evicted rewalk");

        // Flush while the level-0 read is outstanding; memory answers 3 cycles later.
        mmu_flush_i = 1'b1;
        @(negedge clk);
        mmu_flush_i = 1'b0;
        mem_delay = 3;
        mmu_enable_i = 1'b1;
        mmu_priv_u_i = 1'b0;
        mmu_satp_asid_i = 9'd0;
        mmu_vaddr_i = 32'h4000_1004;
        mmu_req_valid_i = 1'b1;
        cyc = 0;
        #1;
        while (!(mmu_mem_req_o && mmu_mem_addr_o == 32'h8000_1004) && cyc < 40) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        checkOutput("abort reached l0", 32'(cyc >= 40), 32'd0);
        mmu_flush_i = 1'b1;
        @(negedge clk);
        mmu_flush_i = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("abort held mem_req %0d", k), 32'(mmu_mem_req_o), 32'd1);
            checkOutput($sformatf("abort held addr %0d", k), mmu_mem_addr_o, 32'h8000_1004);
            checkOutput($sformatf("abort no resp %0d", k), 32'(mmu_resp_valid_o), 32'd0);
            @(negedge clk);
            #1;
        end
        checkOutput("abort idle mem_req", 32'(mmu_mem_req_o), 32'd0);
        checkOutput("abort idle no resp", 32'(mmu_resp_valid_o), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("abort no fill resp", 32'(mmu_resp_valid_o), 32'd0);
        checkOutput("abort rewalk mem_req", 32'(mmu_mem_req_o), 32'd1);
        checkOutput("abort rewalk addr", mmu_mem_addr_o, 32'h8000_0400);
        cyc = 0;
        while (!mmu_resp_valid_o && cyc < 60) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        checkOutput("abort rewalk timeout", 32'(cyc >= 60), 32'd0);
        checkOutput("abort rewalk paddr", mmu_paddr_o, 32'h8012_3004);
        checkOutput("abort rewalk fault", 32'(mmu_page_fault_o), 32'd0);
        mmu_req_valid_i = 1'b0;
        mem_delay = 0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
